uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Parametrised UART transmitter: runtime-free, elaboration-configured frame (5-9 data bits, 1/2 stop bits,
//  optional parity). Adds a one-entry holding register so consecutive frames leave with zero idle gap.
//  Accepts data on any clock (valid/ready), not only on baud ticks. Sits between host logic and the TX pad.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  system clock in Hz
//  BAUD_RATE   9600        line rate in bit/s; DIV = (CLOCK_FREQ + BAUD_RATE/2)/BAUD_RATE clocks per bit
//  DATA_BITS   8           data bits per frame, legal 5..9, LSB first
//  STOP_BITS   1           stop bits, legal 1 or 2
//  PARITY_ODD  0           0 = even, 1 = odd parity (used only when UART_TX_PARITY_EN defined)
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  rst       in   1          synchronous, active-high reset
//  tx_data   in   DATA_BITS  frame payload, sampled on accept
//  tx_valid  in   1          payload valid; must hold tx_data stable until accepted
//  tx_ready  out  1          holding register empty; accept = tx_valid && tx_ready at posedge
//  tx_busy   out  1          FSM not IDLE (frame on the line)
//  tx_done   out  1          1-cycle pulse on the last clock of the final stop bit
//  tx_pin    out  1          serial line, idles high, registered output
// BEHAVIOUR
//  - Reset (sync, any state, incl. mid-frame): tx_pin=1, tx_ready=1, tx_busy=0, tx_done=0, hold emptied,
//    FSM=IDLE, baud counter=0. Partially sent frame is aborted; no stop bit is completed.
//  - Accept: hold<=tx_data, hold_full<=1; tx_ready = !hold_full (registered). No accept while full.
//  - FSM states IDLE, START, DATA, PARITY, STOP (uart_pkg enum).
//    IDLE: tx_pin=1; if hold_full -> START next edge: shift<=hold, hold_full<=0, tx_pin<=0, baud cnt cleared.
//    Latency: accept at edge N -> tx_pin falls at edge N+1 (when idle).
//    Every non-IDLE state bit lasts exactly DIV clocks, timed by baud tick (cnt==DIV-1, cnt restarts at 0).
//    START -> DATA: tx_pin<=shift[0], shift right; DATA counts DATA_BITS bits, bit index 0..DATA_BITS-1.
//    DATA last bit -> PARITY (macro defined) else STOP. STOP holds tx_pin=1 for STOP_BITS*DIV clocks.
//    STOP end: tx_done=1 that cycle; if hold_full -> START directly (back-to-back, no idle bit), else IDLE.
//  - Hold may be refilled as soon as it is moved to shift (tx_ready returns high 1 cycle after START entry).
//  - Load and accept cannot coincide (accept requires empty hold); no simultaneous-event conflict.
//  - Elaboration error ($error in generate) if DATA_BITS not in 5..9, STOP_BITS not 1/2, or DIV < 2.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state between DATA and STOP, tx_pin = ^data ^ PARITY_ODD,
//    frame = 1+DATA_BITS+1+STOP_BITS bits.
//  Undefined: no PARITY state/logic, frame = 1+DATA_BITS+STOP_BITS bits; PARITY_ODD ignored.
// STRUCTURE
//  uart_pkg: tx_state_t enum (IDLE/START/DATA/PARITY/STOP), calc_div() function, legal-range constants
//    DATA_BITS_MIN=5, DATA_BITS_MAX=9.
//  Sub-module uart_baud_gen (params DIV; ports clk, rst, clear, tick): counter with clear, replaces the
//    free-running generator so every frame's start bit is a full period.
// TESTING  (bench params CLOCK_FREQ=16, BAUD_RATE=1 -> DIV=16)
//  1 0xA5, 8N1, idle: tx_pin low at accept+1 for 16 clks, bits 1,0,1,0,0,1,0,1 x16 clks, stop 16 clks;
//    tx_done at accept+160; tx_busy high 160 clks.
//  2 0x00 then 0xFF with tx_valid held: second start bit begins the clock after first stop ends, no idle;
//    tx_ready low from accept+1 until second frame's START entry +1.
//  3 DATA_BITS=7, STOP_BITS=2, 0x7F: 7 ones, tx_pin high 32 clks after data, frame 160 clks.
//  4 Macro defined, 0x03, PARITY_ODD=0: parity bit 0; PARITY_ODD=1: parity bit 1; frame 176 clks.
//    Macro undefined: frame 160 clks, no parity bit.
//  5 rst pulse during data bit 3 of 0xA5: next edge tx_pin=1, tx_ready=1, tx_busy=0, no tx_done; then
//    0x55 sends a clean full frame.
//  6 tx_valid held high while tx_ready=0 across a frame: exactly one accept per ready window, no duplicate.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: state encoding,
// clocks-per-bit calculation and the legal data-width range.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Rounded-to-nearest clocks per bit.
    function automatic int calc_div(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: tick on the last clock of every DIV-clock period.
// clear restarts the period so a new frame's start bit is always full length.
module uart_baud_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter with a one-entry holding register for gapless back-to-back frames.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_pin
);

    localparam int DIV   = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam int BIT_W = 4;

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_framer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_framer: CLOCK_FREQ/BAUD_RATE must give at least 2 clocks per bit");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_framer: PARITY_ODD must be 0 or 1");
    end

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_pin_q, tx_pin_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 tick;
    logic                 baud_clear;
    logic                 load;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_pin   = tx_pin_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        tx_pin_d    = tx_pin_q;
        bit_cnt_d   = bit_cnt_q;
        baud_clear  = 1'b0;
        load        = 1'b0;
        tx_done     = 1'b0;
        accept      = tx_valid && !hold_full_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_pin_d = 1'b1;
                load     = hold_full_q;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    tx_pin_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_pin_d = parity_q;
`else
                        state_d  = STOP;
                        tx_pin_d = 1'b1;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        tx_pin_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (tick) begin
                    state_d  = STOP;
                    tx_pin_d = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        tx_done = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load needs a full hold and accept needs an empty one, so they never collide.
        if (load) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_pin_d    = 1'b0;
            baud_clear  = 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
`endif
        end
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            tx_pin_q    <= 1'b1;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            tx_pin_q    <= tx_pin_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: three instances (8N1 even, 7 data/2 stop, 8N1 odd parity),
// frames are decoded clock by clock from tx_pin and compared against queued expectations.
module tb_uart_tx_framer;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [8:0] data;
        int         nb;
        int         sb;
        logic       par;
        int         start;
        logic       abort;
    } item_t;

    logic       clk;
    logic       rst;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [2:0] v;
    logic [2:0] ready_w, busy_w, done_w, pin_w;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    int    last_end[3];
    int    hold_free[3];
    item_t exp_q[$];

    uart_tx_framer #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v[0]), .tx_ready(ready_w[0]),
        .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx_pin(pin_w[0]));
    uart_tx_framer #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v[1]), .tx_ready(ready_w[1]),
        .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx_pin(pin_w[1]));
    uart_tx_framer #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v[2]), .tx_ready(ready_w[2]),
        .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx_pin(pin_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nb_of(input int idx);
        return (idx == 1) ? 7 : 8;
    endfunction

    function automatic int sb_of(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int idx);
        return (1 + nb_of(idx) + (PAR_EN ? 1 : 0) + sb_of(idx)) * DIV;
    endfunction

    // Present data, wait for the handshake, check its timing against the model, queue the frame.
    task automatic send(input int idx, input logic [8:0] data, input bit keep, input bit abort);
        item_t it;
        int    c;
        int    a;
        int    exp_acc;
        int    guard;
        logic [8:0] m;
        c = cyc;
        case (idx)
            0: d0 = data[7:0];
            1: d1 = data[6:0];
            default: d2 = data[7:0];
        endcase
        v[idx] = 1'b1;
        guard = 0;
        while (ready_w[idx] !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("accept_timeout_u%0d", idx), 32'(guard >= 1000), 32'd0);
        @(posedge clk);
        #1;
        a = cyc;
        exp_acc = (c + 1 > hold_free[idx] + 1) ? c + 1 : hold_free[idx] + 1;
        check($sformatf("accept_cycle_u%0d", idx), a, exp_acc);
        if (!keep) v[idx] = 1'b0;
        m        = data & 9'((1 << nb_of(idx)) - 1);
        it.idx   = idx;
        it.data  = m;
        it.nb    = nb_of(idx);
        it.sb    = sb_of(idx);
        it.par   = (^m) ^ (idx == 2);
        it.start = (a + 1 > last_end[idx]) ? a + 1 : last_end[idx];
        it.abort = abort;
        exp_q.push_back(it);
        hold_free[idx] = it.start;
        last_end[idx]  = it.start + frame_len(idx);
    endtask

    task automatic wait_frames_done(input int idx);
        while (cyc < last_end[idx]) @(negedge clk);
        check($sformatf("busy_after_frame_u%0d", idx), busy_w[idx], 1'b0);
        check($sformatf("ready_after_frame_u%0d", idx), ready_w[idx], 1'b1);
        check($sformatf("pin_after_frame_u%0d", idx), pin_w[idx], 1'b1);
    endtask

    task automatic monitor(input int idx);
        item_t it;
        int    len;
        logic  e;
        logic  got;
        bit    aborted;
        bit    done_bad;
        bit    busy_bad;
        int    guard;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (rst || pin_w[idx] !== 1'b0) continue;
            if (exp_q.size() == 0 || exp_q[0].idx != idx) begin
                check($sformatf("unexpected_frame_u%0d", idx), 32'd1, 32'd0);
                guard = 0;
                while (pin_w[idx] !== 1'b1 && guard < 20 * DIV) begin
                    @(negedge clk);
                    guard++;
                end
                continue;
            end
            it = exp_q.pop_front();
            check($sformatf("start_cycle_u%0d", idx), cyc, it.start);
            len      = 1 + it.nb + (PAR_EN ? 1 : 0) + it.sb;
            aborted  = 1'b0;
            done_bad = 1'b0;
            busy_bad = 1'b0;
            for (int b = 0; b < len && !aborted; b++) begin
                if (b == 0) e = 1'b0;
                else if (b <= it.nb) e = it.data[b-1];
                else if (PAR_EN && b == it.nb + 1) e = it.par;
                else e = 1'b1;
                got = e;
                for (int k = 0; k < DIV && !aborted; k++) begin
                    if (b != 0 || k != 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                    end else begin
                        if (pin_w[idx] !== e) got = pin_w[idx];
                        if (done_w[idx] !== ((b == len - 1) && (k == DIV - 1))) done_bad = 1'b1;
                        if (busy_w[idx] !== 1'b1) busy_bad = 1'b1;
                    end
                end
                if (!aborted) check($sformatf("u%0d_data%0h_bit%0d", idx, it.data, b), got, e);
            end
            check($sformatf("abort_u%0d", idx), aborted, it.abort);
            check($sformatf("done_pulse_u%0d_data%0h", idx, it.data), done_bad, 1'b0);
            check($sformatf("busy_during_u%0d_data%0h", idx, it.data), busy_bad, 1'b0);
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        rst = 1'b1;
        v   = 3'b000;
        d0  = '0;
        d1  = '0;
        d2  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_pin_u%0d", i), pin_w[i], 1'b1);
            check($sformatf("reset_ready_u%0d", i), ready_w[i], 1'b1);
            check($sformatf("reset_busy_u%0d", i), busy_w[i], 1'b0);
            check($sformatf("reset_done_u%0d", i), done_w[i], 1'b0);
            last_end[i]  = cyc;
            hold_free[i] = cyc;
        end
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: single 8N1 frame from idle
        send(0, 9'h0A5, 1'b0, 1'b0);
        wait_frames_done(0);

        // 2: back-to-back frames with tx_valid held between them
        send(0, 9'h000, 1'b1, 1'b0);
        send(0, 9'h0FF, 1'b0, 1'b0);
        wait_frames_done(0);

        // 3: 7 data bits, 2 stop bits
        send(1, 9'h07F, 1'b0, 1'b0);
        wait_frames_done(1);

        // 4: parity even and odd (bit present only when the option is built in)
        send(0, 9'h003, 1'b0, 1'b0);
        wait_frames_done(0);
        send(2, 9'h003, 1'b0, 1'b0);
        wait_frames_done(2);

        // 5: reset during data bit 3, then a clean frame
        send(0, 9'h0A5, 1'b0, 1'b1);
        repeat (1 + DIV + 3 * DIV + 5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midframe_reset_pin", pin_w[0], 1'b1);
        check("midframe_reset_ready", ready_w[0], 1'b1);
        check("midframe_reset_busy", busy_w[0], 1'b0);
        check("midframe_reset_done", done_w[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            last_end[i]  = cyc;
            hold_free[i] = cyc;
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_pin_idle", pin_w[0], 1'b1);
        send(0, 9'h055, 1'b0, 1'b0);
        wait_frames_done(0);

        // 6: tx_valid held across several frames with identical data
        send(0, 9'h03C, 1'b1, 1'b0);
        send(0, 9'h03C, 1'b1, 1'b0);
        send(0, 9'h03C, 1'b0, 1'b0);
        wait_frames_done(0);

        repeat (3 * DIV) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
